mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the parameters below; constants shared via the team constants header.
- MEM_ADDR_BITS, 28, memory line address width
- MEM_DATA_BITS, 128, beat width
- MEM_DATA_CYCLES, 4, beats per line
- MEM_TAG_BITS, 4, transaction tag width
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-low
- ic_req_valid / ic_req_ready  in / out  1  icache refill request handshake
- ic_req_addr  in  MEM_ADDR_BITS  icache line address
- ic_resp_valid  out  1  icache read beat valid
- ic_resp_data  out  MEM_DATA_BITS  icache read beat
- dc_req_valid / dc_req_ready  in / out  1  dcache request handshake
- dc_req_addr  in  MEM_ADDR_BITS  dcache line address
- dc_req_rw  in  1  1 = writeback, 0 = refill
- dc_req_data_valid / dc_req_data_ready  in / out  1  writeback beat handshake
- dc_req_data_bits  in  MEM_DATA_BITS  writeback beat
- dc_req_data_mask  in  MEM_DATA_BITS/8  byte mask
- dc_resp_valid  out  1  dcache read beat valid
- dc_resp_data  out  MEM_DATA_BITS  dcache read beat
- mem_req_valid / mem_req_ready  out / in  1  memory command handshake
- mem_req_rw, mem_req_addr, mem_req_tag  out  1 / MEM_ADDR_BITS / MEM_TAG_BITS  command fields
- mem_req_data_valid / mem_req_data_ready  out / in  1  write beat handshake
- mem_req_data_bits, mem_req_data_mask  out  MEM_DATA_BITS / MEM_DATA_BITS/8  write beat
- mem_resp_valid  in  1; mem_resp_data  in  MEM_DATA_BITS; mem_resp_tag  in  MEM_TAG_BITS
- busy  out  1  high whenever state != IDLE

Function
REQ-003 The block SHALL allow exactly one memory transaction outstanding at a time.
REQ-004 FSM states SHALL be IDLE, CMD, WDATA, RDATA.
REQ-005 IDLE: winner's req_ready SHALL be asserted combinationally in the same cycle; loser's ready 0; on valid&ready latch addr, rw (icache rw=0), owner; next state CMD.
REQ-006 Arbitration: only one valid -> it wins; both valid -> requester not granted last wins; last_grant updates on each accepted request.
REQ-007 CMD: mem_req_valid=1 with latched rw/addr and tag (icache 4'd0, dcache 4'd1), held stable until mem_req_ready; then WDATA if rw=1 else RDATA.
REQ-008 WDATA: mem_req_data_valid=dc_req_data_valid, dc_req_data_ready=mem_req_data_ready, data/mask passed combinationally; beat counter increments per completed beat; after beat MEM_DATA_CYCLES-1 completes -> IDLE.
REQ-009 RDATA: each mem_resp_valid with tag equal to owner's tag SHALL produce one-cycle owner resp_valid with mem_resp_data, zero added latency; mismatched tags ignored; after MEM_DATA_CYCLES matching beats -> IDLE.
REQ-010 Beat counter SHALL be log2(MEM_DATA_CYCLES) bits, wrap to 0 at transaction end.
REQ-011 mem_resp_valid in IDLE, CMD or WDATA SHALL be ignored.
REQ-012 A request arriving in the cycle a transaction ends (last beat) SHALL NOT be accepted until the following IDLE cycle (one bubble).
REQ-013 Non-owner resp_valid, and all ready/valid outputs not named for the current state, SHALL be 0.

Reset
REQ-014 While reset=0 at a clock edge: state<=IDLE, beat counter<=0, last_grant<=icache (dcache wins first tie), latched fields<=0.
REQ-015 While reset=0, all valid and ready outputs and busy SHALL be 0.
REQ-016 Reset mid-transaction SHALL abandon it; stale memory beats after reset are dropped per REQ-011.

Structure
REQ-017 MEM_* widths, tag constants and state encodings SHALL live in the shared constants header.
REQ-018 Tie-breaking SHALL be a sub-module rr_arbiter_2 (two requests, last_grant register, one-hot grant).

Verification
REQ-019 Bench SHALL cover:
- ic read alone, addr 28'h0000040, mem_req_ready delayed 3 cycles -> one command tag 0, 4 ic_resp beats, busy falls after beat 4.
- ic and dc valid same cycle after reset -> dc granted first (tag 1), ic granted on next IDLE.
- dc writeback addr 28'h00000A0, mem_req_data_ready toggling 1/0 -> exactly 4 beats, data/mask unaltered, dc_req_data_ready mirrors mem ready.
- RDATA with interleaved mem_resp tag 4'd7 beat -> no resp_valid for it; transaction completes after 4 tag-matched beats.
- reset=0 during RDATA beat 2 -> next cycle IDLE, outputs 0; remaining 2 beats produce no resp_valid.
- back-to-back dc requests with ic pending -> grants alternate dc, ic, dc.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: bus widths, requester tags,
// FSM state encoding and requester identity.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_BITS   = 28;
    localparam int MEM_DATA_BITS   = 128;
    localparam int MEM_DATA_CYCLES = 4;
    localparam int MEM_TAG_BITS    = 4;
    localparam int MEM_MASK_BITS   = MEM_DATA_BITS / 8;
    localparam int BEAT_BITS       = $clog2(MEM_DATA_CYCLES);

    localparam logic [MEM_TAG_BITS-1:0] TAG_IC = 4'd0;
    localparam logic [MEM_TAG_BITS-1:0] TAG_DC = 4'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    function automatic logic [MEM_TAG_BITS-1:0] owner_tag(input owner_e owner);
        return (owner == OWN_DC) ? TAG_DC : TAG_IC;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and memory-side buses seen by the arbiter.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                     ic_req_valid;
    logic                     ic_req_ready;
    logic [MEM_ADDR_BITS-1:0] ic_req_addr;
    logic                     ic_resp_valid;
    logic [MEM_DATA_BITS-1:0] ic_resp_data;

    logic                     dc_req_valid;
    logic                     dc_req_ready;
    logic [MEM_ADDR_BITS-1:0] dc_req_addr;
    logic                     dc_req_rw;
    logic                     dc_req_data_valid;
    logic                     dc_req_data_ready;
    logic [MEM_DATA_BITS-1:0] dc_req_data_bits;
    logic [MEM_MASK_BITS-1:0] dc_req_data_mask;
    logic                     dc_resp_valid;
    logic [MEM_DATA_BITS-1:0] dc_resp_data;

    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_rw;
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;
    logic [MEM_TAG_BITS-1:0]  mem_req_tag;
    logic                     mem_req_data_valid;
    logic                     mem_req_data_ready;
    logic [MEM_DATA_BITS-1:0] mem_req_data_bits;
    logic [MEM_MASK_BITS-1:0] mem_req_data_mask;
    logic                     mem_resp_valid;
    logic [MEM_DATA_BITS-1:0] mem_resp_data;
    logic [MEM_TAG_BITS-1:0]  mem_resp_tag;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_addr, dc_req_rw,
        input  dc_req_data_valid, dc_req_data_bits, dc_req_data_mask,
        output dc_req_ready, dc_req_data_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready,
        input  mem_resp_valid, mem_resp_data, mem_resp_tag
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_addr, dc_req_rw,
        output dc_req_data_valid, dc_req_data_bits, dc_req_data_mask,
        input  dc_req_ready, dc_req_data_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready,
        output mem_resp_valid, mem_resp_data, mem_resp_tag
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter_2.sv
// Two-way round-robin tie-breaker: a lone request always wins, and on a tie
// the requester that was not granted last wins.
module rr_arbiter_2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    owner_e last_q;

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = (last_q == OWN_DC) ? 2'b01 : 2'b10;
        end
    end

    // Starting from "icache last" makes the dcache win the first tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= OWN_IC;
        end else if (en_i && (|req_i)) begin
            last_q <= grant_o[1] ? OWN_DC : OWN_IC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache refills and dcache refills/writebacks,
// one transaction outstanding at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          busy,
    output logic [1:0]    dbg_state_o
);

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(MEM_DATA_CYCLES - 1);

    arb_state_e               state_q;
    logic [MEM_ADDR_BITS-1:0] addr_q;
    logic                     rw_q;
    owner_e                   owner_q;
    logic [BEAT_BITS-1:0]     beat_q;

    logic [1:0] grant;
    logic       in_idle;
    logic       accept;
    logic       wbeat_done;
    logic       rbeat_match;

    assign in_idle = reset && (state_q == IDLE);
    assign accept  = in_idle && (|({bus.dc_req_valid, bus.ic_req_valid} & grant));

    rr_arbiter_2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req_i   ({bus.dc_req_valid, bus.ic_req_valid}),
        .en_i    (in_idle),
        .grant_o (grant)
    );

    assign wbeat_done  = (state_q == WDATA) && bus.dc_req_data_valid && bus.mem_req_data_ready;
    assign rbeat_match = (state_q == RDATA) && bus.mem_resp_valid
                         && (bus.mem_resp_tag == owner_tag(owner_q));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            owner_q <= OWN_IC;
            beat_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= grant[1] ? bus.dc_req_addr : bus.ic_req_addr;
                        rw_q    <= grant[1] && bus.dc_req_rw;
                        owner_q <= grant[1] ? OWN_DC : OWN_IC;
                        state_q <= CMD;
                    end
                end
                CMD: begin
                    if (bus.mem_req_ready) begin
                        state_q <= rw_q ? WDATA : RDATA;
                    end
                end
                WDATA, RDATA: begin
                    if (wbeat_done || rbeat_match) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            beat_q <= beat_q + BEAT_BITS'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ic_req_ready = in_idle && grant[0];
    assign bus.dc_req_ready = in_idle && grant[1];

    assign bus.mem_req_valid = reset && (state_q == CMD);
    assign bus.mem_req_rw    = rw_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_tag   = owner_tag(owner_q);

    // Write beats flow straight through; only the handshake is gated by state.
    assign bus.mem_req_data_valid = reset && (state_q == WDATA) && bus.dc_req_data_valid;
    assign bus.dc_req_data_ready  = reset && (state_q == WDATA) && bus.mem_req_data_ready;
    assign bus.mem_req_data_bits  = bus.dc_req_data_bits;
    assign bus.mem_req_data_mask  = bus.dc_req_data_mask;

    assign bus.ic_resp_valid = reset && rbeat_match && (owner_q == OWN_IC);
    assign bus.dc_resp_valid = reset && rbeat_match && (owner_q == OWN_DC);
    assign bus.ic_resp_data  = bus.mem_resp_data;
    assign bus.dc_resp_data  = bus.mem_resp_data;

    assign busy        = reset && (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// model of the arbitration and beat-forwarding rules.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic       clk;
    logic       reset;
    logic       busy;
    logic [1:0] dbg_state;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    // ---------------- scoreboard / model state ----------------
    logic [127:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    bit m_last_dc;   // model: dcache was granted most recently
    bit m_owner_dc;  // model: current transaction belongs to dcache
    bit m_rw;
    logic [27:0] m_addr;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int cycles);
        reset = 1'b0;
        bus.ic_req_valid = 1'b1;
        bus.dc_req_valid = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_tag = 4'd0;
        bus.dc_req_data_valid = 1'b1;
        bus.mem_req_data_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            #1;
            chk("rst_ic_ready", bus.ic_req_ready, 1'b0);
            chk("rst_dc_ready", bus.dc_req_ready, 1'b0);
            chk("rst_mem_valid", bus.mem_req_valid, 1'b0);
            chk("rst_wdata_valid", bus.mem_req_data_valid, 1'b0);
            chk("rst_wdata_ready", bus.dc_req_data_ready, 1'b0);
            chk("rst_ic_resp", bus.ic_resp_valid, 1'b0);
            chk("rst_dc_resp", bus.dc_resp_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            @(negedge clk);
        end
        bus.ic_req_valid = 1'b0;
        bus.dc_req_valid = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.dc_req_data_valid = 1'b0;
        bus.mem_req_data_ready = 1'b0;
        reset = 1'b1;
        m_last_dc = 1'b0;
    endtask

    // Present requests in IDLE, check the grant, and let the winner's handshake complete.
    task automatic issue(input bit icv, input bit dcv, input logic [27:0] ica,
                         input logic [27:0] dca, input bit dcrw, input bit keep);
        bit win_dc;
        bus.ic_req_valid = icv;
        bus.ic_req_addr = ica;
        bus.dc_req_valid = dcv;
        bus.dc_req_addr = dca;
        bus.dc_req_rw = dcrw;
        #1;
        win_dc = dcv && (!icv || !m_last_dc);
        chk("grant_ic_ready", bus.ic_req_ready, icv && !win_dc);
        chk("grant_dc_ready", bus.dc_req_ready, win_dc);
        chk("idle_busy", busy, 1'b0);
        m_last_dc = win_dc;
        m_owner_dc = win_dc;
        m_rw = win_dc && dcrw;
        m_addr = win_dc ? dca : ica;
        @(negedge clk);
        if (!keep) begin
            if (win_dc) bus.dc_req_valid = 1'b0;
            else bus.ic_req_valid = 1'b0;
        end
    endtask

    // Memory side: stall the command for 'delay' cycles (with stray beats that must be ignored).
    task automatic cmd_phase(input int delay);
        int waited = 0;
        #1;
        while (!bus.mem_req_valid && waited < 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("cmd_valid", bus.mem_req_valid, 1'b1);
        chk("cmd_rw", bus.mem_req_rw, m_rw);
        chk("cmd_addr", bus.mem_req_addr, m_addr);
        chk("cmd_tag", bus.mem_req_tag, m_owner_dc ? 4'd1 : 4'd0);
        chk("cmd_busy", busy, 1'b1);
        for (int i = 0; i < delay; i++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_tag = m_owner_dc ? 4'd1 : 4'd0;
            bus.mem_resp_data = rand128();
            @(negedge clk);
            #1;
            chk("cmd_hold_valid", bus.mem_req_valid, 1'b1);
            chk("cmd_hold_addr", bus.mem_req_addr, m_addr);
            chk("cmd_stray_ic", bus.ic_resp_valid, 1'b0);
            chk("cmd_stray_dc", bus.dc_resp_valid, 1'b0);
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic read_beat(input logic [3:0] tag, input bit expect_resp, input bit exp_busy);
        logic [127:0] d;
        d = rand128();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_tag = tag;
        bus.mem_resp_data = d;
        if (expect_resp) exp_q.push_back(d);
        #1;
        chk("resp_ic_valid", bus.ic_resp_valid, expect_resp && !m_owner_dc);
        chk("resp_dc_valid", bus.dc_resp_valid, expect_resp && m_owner_dc);
        if (expect_resp) chk("resp_data", m_owner_dc ? bus.dc_resp_data : bus.ic_resp_data, exp_q.pop_front());
        chk("rd_ic_ready", bus.ic_req_ready, 1'b0);
        chk("rd_dc_ready", bus.dc_req_ready, 1'b0);
        chk("rd_mem_valid", bus.mem_req_valid, 1'b0);
        chk("rd_busy", busy, exp_busy);
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
    endtask

    // Four tag-matched beats; a foreign-tag beat is slipped in before beat junk_at (if < 4).
    task automatic read_phase(input int junk_at);
        for (int b = 0; b < MEM_DATA_CYCLES; b++) begin
            if (b == junk_at) read_beat(4'd7, 1'b0, 1'b1);
            read_beat(m_owner_dc ? 4'd1 : 4'd0, 1'b1, 1'b1);
        end
        #1;
        chk("rd_end_busy", busy, 1'b0);
    endtask

    task automatic write_phase(input bit gaps);
        logic [127:0] d[MEM_DATA_CYCLES];
        logic [15:0]  m[MEM_DATA_CYCLES];
        int done = 0;
        int cyc = 0;
        for (int i = 0; i < MEM_DATA_CYCLES; i++) begin
            d[i] = rand128();
            m[i] = 16'($urandom);
            exp_q.push_back(d[i]);
        end
        while (done < MEM_DATA_CYCLES && cyc < 40) begin
            bus.dc_req_data_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.dc_req_data_bits = d[done];
            bus.dc_req_data_mask = m[done];
            bus.mem_req_data_ready = (cyc % 2 == 0);
            #1;
            chk("wr_valid", bus.mem_req_data_valid, bus.dc_req_data_valid);
            chk("wr_ready_mirror", bus.dc_req_data_ready, bus.mem_req_data_ready);
            chk("wr_mask", bus.mem_req_data_mask, m[done]);
            chk("wr_busy", busy, 1'b1);
            if (bus.dc_req_data_valid && bus.mem_req_data_ready) begin
                chk("wr_data", bus.mem_req_data_bits, exp_q.pop_front());
                done++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("wr_beats", done, MEM_DATA_CYCLES);
        bus.dc_req_data_valid = 1'b1;
        bus.mem_req_data_ready = 1'b1;
        #1;
        chk("wr_extra_ready", bus.dc_req_data_ready, 1'b0);
        chk("wr_extra_valid", bus.mem_req_data_valid, 1'b0);
        chk("wr_end_busy", busy, 1'b0);
        @(negedge clk);
        bus.dc_req_data_valid = 1'b0;
        bus.mem_req_data_ready = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset = 1'b0;
        bus.ic_req_valid = 1'b0;
        bus.ic_req_addr = '0;
        bus.dc_req_valid = 1'b0;
        bus.dc_req_addr = '0;
        bus.dc_req_rw = 1'b0;
        bus.dc_req_data_valid = 1'b0;
        bus.dc_req_data_bits = '0;
        bus.dc_req_data_mask = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_req_data_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = '0;
        bus.mem_resp_tag = '0;

        // icache read alone, command stalled three cycles
        do_reset(3);
        chk("dbg_state_idle", dbg_state, 2'd0);
        issue(1'b1, 1'b0, 28'h0000040, 28'h0, 1'b0, 1'b0);
        cmd_phase(3);
        read_phase(MEM_DATA_CYCLES);

        // simultaneous requests after reset: dcache first, icache on the next IDLE
        do_reset(2);
        issue(1'b1, 1'b1, 28'h0000100, 28'h0000200, 1'b0, 1'b0);
        cmd_phase(0);
        read_phase(MEM_DATA_CYCLES);
        issue(1'b1, 1'b0, 28'h0000100, 28'h0, 1'b0, 1'b0);
        cmd_phase(1);
        read_phase(MEM_DATA_CYCLES);

        // dcache writeback with memory ready toggling
        issue(1'b0, 1'b1, 28'h0, 28'h00000A0, 1'b1, 1'b0);
        cmd_phase(2);
        write_phase(1'b0);

        // foreign tag interleaved in a read
        issue(1'b1, 1'b0, 28'($urandom), 28'h0, 1'b0, 1'b0);
        cmd_phase(0);
        read_phase(2);

        // reset during the second read beat abandons the transaction
        issue(1'b1, 1'b0, 28'($urandom), 28'h0, 1'b0, 1'b0);
        cmd_phase(0);
        read_beat(4'd0, 1'b1, 1'b1);
        reset = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_tag = 4'd0;
        bus.mem_resp_data = rand128();
        #1;
        chk("rst_mid_ic_resp", bus.ic_resp_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        m_last_dc = 1'b0;
        #1;
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_mem_valid", bus.mem_req_valid, 1'b0);
        read_beat(4'd0, 1'b0, 1'b0);
        read_beat(4'd0, 1'b0, 1'b0);

        // dcache requesting back-to-back while icache waits: dc, ic, dc
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 1'b1, 28'h0000300, 28'h0000400, 1'b0, 1'b1);
            cmd_phase(0);
            read_phase(MEM_DATA_CYCLES);
        end
        chk("alt_third_dc", bus.mem_req_tag, 4'd1);
        bus.ic_req_valid = 1'b0;
        bus.dc_req_valid = 1'b0;

        // randomized transactions
        for (int t = 0; t < 12; t++) begin
            int sel;
            sel = $urandom_range(1, 3);
            issue(sel[0], sel[1], 28'($urandom), 28'($urandom), 1'($urandom), 1'b0);
            bus.ic_req_valid = 1'b0;
            bus.dc_req_valid = 1'b0;
            cmd_phase($urandom_range(0, 3));
            if (m_rw) write_phase(1'b1);
            else read_phase($urandom_range(0, 5));
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
